// File: rtl/traffic_queue_sensor.sv
// Per-lane traffic queue counter with headway-paced departures on green,
// 1st/5th-car sensors, sticky overflow flags and a registered lamp-fault flag.
module traffic_queue_sensor #(
    parameter int QMAX      = 15,
    parameter int HEADWAY   = 2,
    parameter int FS_THRESH = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  car_arrive,
    input  logic [3:0]  red,
    input  logic [3:0]  green,
    input  logic [3:0]  yellow,
    output logic [3:0]  ss_out,
    output logic [3:0]  fs_out,
    output logic [15:0] q_len,
    output logic [3:0]  ovf,
    output logic        light_err
);

    localparam logic [3:0] QMAX_C  = 4'(QMAX);
    localparam logic [3:0] HW_LAST = 4'(HEADWAY - 1);
    localparam logic [3:0] FS_C    = 4'(FS_THRESH);

    logic [3:0] q_q [4];
    logic [3:0] q_d [4];
    logic [3:0] h_q [4];
    logic [3:0] h_d [4];
    logic [3:0] ovf_q, ovf_d;
    logic       light_err_q, light_err_d;

    logic [3:0] slot;
    logic [3:0] depart;
    logic [3:0] lane_bad;
    logic [2:0] go_cnt;

    // Headway timing and queue arithmetic, fully independent per lane
    always_comb begin
        slot   = '0;
        depart = '0;
        ovf_d  = ovf_q;
        for (int i = 0; i < 4; i++) begin
            h_d[i] = 4'd0;
            q_d[i] = q_q[i];
            if (green[i]) begin
                if (h_q[i] == HW_LAST) begin
                    slot[i] = 1'b1;
                end else begin
                    h_d[i] = h_q[i] + 4'd1;
                end
            end
            depart[i] = slot[i] && (q_q[i] != 4'd0);
            if (car_arrive[i] && !depart[i]) begin
                if (q_q[i] == QMAX_C) begin
                    ovf_d[i] = 1'b1;
                end else begin
                    q_d[i] = q_q[i] + 4'd1;
                end
            end else if (!car_arrive[i] && depart[i]) begin
                q_d[i] = q_q[i] - 4'd1;
            end
        end
    end

    // A lane must show exactly one lamp; at most one lane may be off red
    always_comb begin
        lane_bad = '0;
        go_cnt   = 3'd0;
        for (int i = 0; i < 4; i++) begin
            lane_bad[i] = ({1'b0, red[i]} + {1'b0, green[i]} + {1'b0, yellow[i]}) != 2'd1;
            go_cnt      = go_cnt + {2'b00, ~red[i]};
        end
        light_err_d = (|lane_bad) || (go_cnt > 3'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                q_q[i] <= 4'd0;
                h_q[i] <= 4'd0;
            end
            ovf_q       <= 4'd0;
            light_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                q_q[i] <= q_d[i];
                h_q[i] <= h_d[i];
            end
            ovf_q       <= ovf_d;
            light_err_q <= light_err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            q_len[4*i +: 4] = q_q[i];
            ss_out[i]       = (q_q[i] != 4'd0);
            fs_out[i]       = (q_q[i] >= FS_C);
        end
    end

    assign ovf       = ovf_q;
    assign light_err = light_err_q;

endmodule

// File: tb/tb_traffic_queue_sensor.sv
// Scoreboard bench for traffic_queue_sensor: a cycle-level queue/streak model
// predicts every registered output; directed scenarios plus random traffic.
module tb_traffic_queue_sensor;

    localparam int QMAX      = 15;
    localparam int HEADWAY   = 2;
    localparam int FS_THRESH = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  car_arrive = '0;
    logic [3:0]  red = 4'hF;
    logic [3:0]  green = '0;
    logic [3:0]  yellow = '0;
    logic [3:0]  ss_out;
    logic [3:0]  fs_out;
    logic [15:0] q_len;
    logic [3:0]  ovf;
    logic        light_err;

    typedef struct {
        logic [15:0] q;
        logic [3:0]  ss;
        logic [3:0]  fs;
        logic [3:0]  ov;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    int   mq     [4];
    int   streak [4];
    bit   movf   [4];
    bit   merr;
    bit   model_live = 1'b0;
    exp_t model_e;

    traffic_queue_sensor #(
        .QMAX(QMAX), .HEADWAY(HEADWAY), .FS_THRESH(FS_THRESH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .car_arrive(car_arrive),
        .red(red), .green(green), .yellow(yellow),
        .ss_out(ss_out), .fs_out(fs_out), .q_len(q_len),
        .ovf(ovf), .light_err(light_err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic [3:0] r, input logic [3:0] g,
                                 input logic [3:0] y, input logic rn);
        @(posedge clk);
        #1;
        car_arrive = a;
        red        = r;
        green      = g;
        yellow     = y;
        rst_n      = rn;
    endtask

    // Reference model: a departure slot falls on every HEADWAY-th cycle of an unbroken green streak
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                mq[i] = 0; streak[i] = 0; movf[i] = 0;
            end
            merr       = 0;
            model_live = 1'b1;
        end else if (model_live) begin
            int nbad, ngo;
            nbad = 0; ngo = 0;
            for (int i = 0; i < 4; i++) begin
                if (int'(red[i]) + int'(green[i]) + int'(yellow[i]) != 1) nbad++;
                if (!red[i]) ngo++;
            end
            merr = (nbad > 0) || (ngo > 1);
            for (int i = 0; i < 4; i++) begin
                bit dep;
                dep = 0;
                if (green[i]) begin
                    streak[i]++;
                    if ((streak[i] % HEADWAY == 0) && mq[i] > 0) dep = 1;
                end else begin
                    streak[i] = 0;
                end
                if (car_arrive[i] && !dep) begin
                    if (mq[i] == QMAX) movf[i] = 1;
                    else mq[i]++;
                end else if (dep && !car_arrive[i]) begin
                    mq[i]--;
                end
            end
        end
        if (model_live) begin
            for (int i = 0; i < 4; i++) begin
                model_e.q[4*i +: 4] = 4'(mq[i]);
                model_e.ss[i]       = (mq[i] != 0);
                model_e.fs[i]       = (mq[i] >= FS_THRESH);
                model_e.ov[i]       = movf[i];
            end
            model_e.err = merr;
            exp_q.push_back(model_e);
        end
    end

    // Monitor: every cycle the DUT presents a fresh registered state
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("sb_q_len", 32'(q_len), 32'(e.q));
            checkOutput("sb_ss_out", 32'(ss_out), 32'(e.ss));
            checkOutput("sb_fs_out", 32'(fs_out), 32'(e.fs));
            checkOutput("sb_ovf", 32'(ovf), 32'(e.ov));
            checkOutput("sb_light_err", 32'(light_err), 32'(e.err));
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        // Reset overrides arrivals
        applyStimulus(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        applyStimulus(4'hF, 4'hF, 4'h0, 4'h0, 1'b0);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("reset_q_len", 32'(q_len), 32'h0);
        checkOutput("reset_ss", 32'(ss_out), 32'h0);
        checkOutput("reset_fs", 32'(fs_out), 32'h0);
        checkOutput("reset_ovf", 32'(ovf), 32'h0);

        // Five arrivals on lane 0 under all-red
        for (int i = 0; i < 5; i++) begin
            applyStimulus(4'h1, 4'hF, 4'h0, 4'h0, 1'b1);
            if (i == 1) begin
                checkOutput("first_car_ss", 32'(ss_out), 32'h1);
                checkOutput("first_car_fs", 32'(fs_out), 32'h0);
            end
        end
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("five_cars_q0", 32'(q_len[3:0]), 32'd5);
        checkOutput("five_cars_fs", 32'(fs_out), 32'h1);

        // Ten green cycles drain five cars
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'h0, 4'hE, 4'h1, 4'h0, 1'b1);
            if (i == 2) begin
                checkOutput("drain_q0_after2", 32'(q_len[3:0]), 32'd4);
                checkOutput("drain_fs_drop", 32'(fs_out), 32'h0);
            end
        end
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("drain_q0_empty", 32'(q_len[3:0]), 32'd0);

        // Lane 2: arrival coinciding with a departure slot
        for (int i = 0; i < 3; i++) applyStimulus(4'h4, 4'hF, 4'h0, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hB, 4'h4, 4'h0, 1'b1);
        applyStimulus(4'h4, 4'hB, 4'h4, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("slot_plus_arrival_q2", 32'(q_len[11:8]), 32'd3);

        // Lane 1 saturation and sticky overflow
        for (int i = 0; i < 16; i++) applyStimulus(4'h2, 4'hF, 4'h0, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("sat_q1", 32'(q_len[7:4]), 32'd15);
        checkOutput("sat_ovf", 32'(ovf), 32'h2);
        for (int i = 0; i < 32; i++) applyStimulus(4'h0, 4'hD, 4'h2, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("drained_q1", 32'(q_len[7:4]), 32'd0);
        checkOutput("ovf_sticky", 32'(ovf), 32'h2);

        // Lamp faults
        applyStimulus(4'h0, 4'hC, 4'h3, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("two_greens_err", 32'(light_err), 32'h1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("err_clears", 32'(light_err), 32'h0);
        applyStimulus(4'h0, 4'hF, 4'h8, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("red_green_err", 32'(light_err), 32'h1);

        // Reset mid-green discards the partial headway
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(4'h1, 4'hF, 4'h0, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hE, 4'h1, 4'h0, 1'b1);
        applyStimulus(4'hF, 4'hE, 4'h1, 4'h0, 1'b0);
        applyStimulus(4'h1, 4'hE, 4'h1, 4'h0, 1'b1);
        checkOutput("midgreen_reset_q", 32'(q_len), 32'h0);
        checkOutput("midgreen_reset_ovf", 32'(ovf), 32'h0);
        applyStimulus(4'h0, 4'hE, 4'h1, 4'h0, 1'b1);
        checkOutput("resume_no_early_dep", 32'(q_len[3:0]), 32'd1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        checkOutput("resume_dep_after_two", 32'(q_len[3:0]), 32'd0);

        // Random traffic, mostly legal lamps, occasional reset
        for (int n = 0; n < 600; n++) begin
            logic [3:0] a, r, g, y;
            int lane, kind;
            lane = $urandom_range(0, 3);
            kind = $urandom_range(0, 3);
            a = 4'($urandom);
            r = 4'hF; g = 4'h0; y = 4'h0;
            if (kind == 1) begin
                r[lane] = 1'b0; g[lane] = 1'b1;
            end else if (kind == 2) begin
                r[lane] = 1'b0; y[lane] = 1'b1;
            end else if (kind == 3) begin
                r = 4'($urandom); g = 4'($urandom); y = 4'($urandom);
            end
            applyStimulus(a, r, g, y, ($urandom_range(0, 59) != 0));
        end
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        applyStimulus(4'h0, 4'hF, 4'h0, 4'h0, 1'b1);
        #5;
        checkOutput("scoreboard_drain", 32'(exp_q.size() <= 1), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
